// File: rtl/seeded_tile_pkg.sv
// Shared state encoding and LEN-generic one-hot helpers for the seeded_tile solver cell.
package tile_pkg;

   localparam int MAXW = 64;

   typedef enum logic [5:0] {
      ST_WAITING = 6'b000001,
      ST_INCRIDX = 6'b000010,
      ST_RQBIAS  = 6'b000100,
      ST_CHECK   = 6'b001000,
      ST_PASSFWD = 6'b010000,
      ST_PASSBAK = 6'b100000
   } tile_state_e;

   // Rotate the low w bits of v up by one, wrapping bit w-1 back to bit 0.
   function automatic logic [MAXW-1:0] onehot_rotl(input logic [MAXW-1:0] v, input int w);
      logic [MAXW-1:0] mask;
      mask = (MAXW'(1) << w) - MAXW'(1);
      return ((v << 1) | (MAXW'(1) & (v >> (w - 1)))) & mask;
   endfunction

   function automatic logic is_onehot0(input logic [MAXW-1:0] v);
      return (v & (v - MAXW'(1))) == '0;
   endfunction

endpackage

// File: rtl/seeded_tile_if.sv
// Bias handshake between a grid cell (master) and its row-bias block (slave).
interface seeded_tile_if #(parameter int LEN = 9);

   logic           rq_valtotry;
   logic [LEN-1:0] biasidx;
   logic           valtotry_vld;
   logic [LEN-1:0] valtotry;
   logic [LEN-1:0] valcannotbe;

   modport master (
      output rq_valtotry, biasidx,
      input  valtotry_vld, valtotry, valcannotbe
   );

   modport slave (
      input  rq_valtotry, biasidx,
      output valtotry_vld, valtotry, valcannotbe
   );

endinterface

// File: rtl/seeded_tile.sv
// One solver-chain grid cell: walks a one-hot bias index, requests candidates and passes control on.
// Optional attempt counter enabled by defining SEEDED_TILE_TRYCOUNT_EN.
module seeded_tile
   import tile_pkg::*;
#(
   parameter int LEN  = 9,
   parameter int TRYW = 8
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            myturn,
   input  logic            enter_bak,
   input  logic            seed_we,
   input  logic [LEN-1:0]  seed,
   seeded_tile_if.master   bias,
   output logic            passfwd,
   output logic            passbak,
   output logic [LEN-1:0]  value,
   output logic            locked
`ifdef SEEDED_TILE_TRYCOUNT_EN
   ,
   output logic [TRYW-1:0] trycount
`endif
);

   localparam int IDXW = LEN + 1;
   typedef logic [IDXW-1:0] idx_t;
   localparam idx_t IDX_SENTINEL = {1'b1, {LEN{1'b0}}};

   if (TRYW < 1) begin : g_tryw_check
      $error("seeded_tile: TRYW must be at least 1");
   end

   tile_state_e    state_q, state_d;
   idx_t           index_q, index_d;
   logic [LEN-1:0] value_q, value_d;
   logic [LEN-1:0] capt_q,  capt_d;
   logic           locked_q, locked_d;
`ifdef SEEDED_TILE_TRYCOUNT_EN
   logic [TRYW-1:0] try_q, try_d;
`endif

   idx_t rotIdx;
   logic accept;

   assign rotIdx = idx_t'(onehot_rotl(MAXW'(index_q), IDXW));

   // A malformed multi-hot reply is rejected just like a neighbour conflict.
   assign accept = (|capt_q) && is_onehot0(MAXW'(capt_q)) && ((capt_q & bias.valcannotbe) == '0);

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      value_d  = value_q;
      capt_d   = capt_q;
      locked_d = locked_q;
`ifdef SEEDED_TILE_TRYCOUNT_EN
      try_d    = try_q;
`endif
      case (state_q)
         ST_WAITING: begin
            if (seed_we) begin
               value_d  = seed;
               locked_d = |seed;
               index_d  = IDX_SENTINEL;
            end else if (myturn) begin
               if (locked_q) begin
                  state_d = enter_bak ? ST_PASSBAK : ST_PASSFWD;
               end else begin
                  value_d = '0;
                  if (!enter_bak) begin
                     index_d = IDX_SENTINEL;
`ifdef SEEDED_TILE_TRYCOUNT_EN
                     try_d   = '0;
`endif
                  end
                  state_d = ST_INCRIDX;
               end
            end
         end
         ST_INCRIDX: begin
            index_d = rotIdx;
            state_d = (rotIdx == IDX_SENTINEL) ? ST_PASSBAK : ST_RQBIAS;
         end
         ST_RQBIAS: begin
            if (bias.valtotry_vld) begin
               capt_d  = bias.valtotry;
`ifdef SEEDED_TILE_TRYCOUNT_EN
               try_d   = (try_q == '1) ? try_q : try_q + TRYW'(1);
`endif
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (accept) begin
               value_d = capt_q;
               state_d = ST_PASSFWD;
            end else begin
               state_d = ST_INCRIDX;
            end
         end
         ST_PASSFWD, ST_PASSBAK: state_d = ST_WAITING;
         default:                state_d = ST_WAITING;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_WAITING;
         index_q  <= IDX_SENTINEL;
         value_q  <= '0;
         capt_q   <= '0;
         locked_q <= 1'b0;
`ifdef SEEDED_TILE_TRYCOUNT_EN
         try_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         value_q  <= value_d;
         capt_q   <= capt_d;
         locked_q <= locked_d;
`ifdef SEEDED_TILE_TRYCOUNT_EN
         try_q    <= try_d;
`endif
      end
   end

   assign bias.rq_valtotry = (state_q == ST_RQBIAS);
   assign bias.biasidx     = (state_q == ST_RQBIAS) ? index_q[LEN-1:0] : '0;
   assign passfwd          = (state_q == ST_PASSFWD);
   assign passbak          = (state_q == ST_PASSBAK);
   assign value            = value_q;
   assign locked           = locked_q;
`ifdef SEEDED_TILE_TRYCOUNT_EN
   assign trycount         = try_q;
`endif

endmodule
